fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin, burst-capable arbiter that shares one FIFO write port among NUM_REQ producers.
//  Sits in front of the FIFO write side, in the write clock domain.
//  Grants one requester at a time, forwards its beats while fifo_full_i is low, then rotates priority.
//  Provides fairness and bounded latency: no requester holds the port for more than MAX_BURST accepted beats.
// PARAMETERS
//  NUM_REQ     4                   number of requesters (>=2)
//  DATA_WIDTH  8                   beat width; matches the FIFO data width
//  MAX_BURST   4                   maximum beats accepted per grant (>=1)
//  ID_WIDTH    $clog2(NUM_REQ)     width of grant_id_o
// PORTS
//  clk_i           in   1                     single clock (the FIFO write clock)
//  rst_i           in   1                     synchronous, active-high reset
//  req_i           in   NUM_REQ               per-requester beat valid; held until acked
//  data_i          in   NUM_REQ*DATA_WIDTH    packed beats; requester n uses [n*DATA_WIDTH +: DATA_WIDTH]
//  ack_o           out  NUM_REQ               one-hot; beat accepted this cycle
//  fifo_full_i     in   1                     FIFO full flag
//  fifo_wr_en_o    out  1                     FIFO write strobe
//  fifo_wr_data_o  out  DATA_WIDTH            FIFO write data
//  grant_o         out  NUM_REQ               registered one-hot owner; 0 in IDLE
//  grant_id_o      out  ID_WIDTH              binary index of the owner; 0 in IDLE
//  busy_o          out  1                     1 while in the BURST state
// BEHAVIOUR
//  Reset: state=IDLE, grant_o=0, grant_id_o=0, busy_o=0, beat_cnt=0, last_owner=NUM_REQ-1.
//    fifo_wr_en_o=0, ack_o=0 and fifo_wr_data_o=0 follow from state=IDLE.
//  FSM has two states, IDLE and BURST.
//  IDLE, any req_i set: pick the first set bit searching last_owner+1, last_owner+2, ... (mod NUM_REQ).
//    Register it into grant_o/grant_id_o, set beat_cnt=0, go to BURST.
//    No write happens in IDLE, so a new grant costs exactly 1 bubble cycle.
//  BURST, combinational write path:
//    fifo_wr_en_o = req_i[owner] & ~fifo_full_i.
//    fifo_wr_data_o = data_i slice of the owner.
//    ack_o[owner] = fifo_wr_en_o. All other ack_o bits are 0.
//  BURST, accepted beat: beat_cnt+1.
//    If beat_cnt==MAX_BURST-1, go to IDLE and set last_owner=owner.
//  BURST, req_i[owner]==0: go to IDLE at the next edge and set last_owner=owner (burst ends early).
//  BURST, fifo_full_i==1 with req_i[owner]==1: hold. No ack, beat_cnt unchanged, stay in BURST.
//  Non-owner requests are ignored until the owner releases the port or reaches MAX_BURST.
//  Requester rule: data_i slice must be stable while req_i is high and ack_o is low.
//  In IDLE with no req: stay in IDLE. last_owner is unchanged.
//  beat_cnt is $clog2(MAX_BURST+1) bits wide and never exceeds MAX_BURST-1.
//  Reset mid-burst: the FSM aborts to IDLE at that edge. No write in the reset cycle.
//    Priority restarts from requester 0.
//  Write/full race: fifo_full_i is sampled combinationally, so a beat is never written into a full FIFO.
//  This block never raises FIFO overflow.
// TESTING
//  T1 reset:
//    Hold rst_i for 3 cycles with all req_i high -> ack_o=0, fifo_wr_en_o=0, grant_o=0, busy_o=0.
//    After release, the first grant goes to requester 0.
//  T2 single burst:
//    Only req_i[2]=1, data 0xA0..0xA5, FIFO not full, MAX_BURST=4.
//    -> 1 bubble, then 0xA0..0xA3 written on consecutive cycles.
//    -> Return to IDLE, 1 bubble, then 0xA4,0xA5.
//  T3 round-robin:
//    req_i=4'b1111 held continuously.
//    -> Grants in order 0,1,2,3,0, each for 4 beats.
//    -> No requester is acked during another's grant.
//  T4 full stall:
//    Owner 1 mid-burst (beat_cnt=2), fifo_full_i=1 for 5 cycles.
//    -> No fifo_wr_en_o or ack_o during the stall; grant_o holds.
//    -> After full drops, exactly 2 more beats are written, then IDLE.
//  T5 early release:
//    Owner 3 drops req after 1 beat; req_i[0]=1 pending.
//    -> IDLE next cycle, then grant to 0 (search starts after 3).
//  T6 reset mid-burst:
//    Assert rst_i during owner 2's beat 2 -> no write that cycle, state IDLE.
//    With req_i=4'b0110, the next grant goes to 1.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers
//   clk_i, rst_i     FIFO write clock, synchronous active-high reset
//   req_i, data_i    per-requester beat valid and packed beat data
//   ack_o            one-hot, beat accepted this cycle
//   fifo_full_i      FIFO full flag
//   fifo_wr_en_o     FIFO write strobe, fifo_wr_data_o write data
//   grant_o          registered one-hot owner, grant_id_o its index, busy_o high while bursting
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
    output logic [NUM_REQ-1:0]            ack_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic [ID_WIDTH-1:0]           grant_id_o,
    output logic                          busy_o
);
    localparam int CW = $clog2(MAX_BURST + 1);
    typedef enum logic {IDLE, BURST} state_t;
    state_t              state;
    logic [CW-1:0]       beat_cnt;
    logic [ID_WIDTH-1:0] last_owner;
    logic [ID_WIDTH-1:0] nxt_id;
    logic [ID_WIDTH-1:0] cand;
    logic                found;
    logic                owner_req;
    logic                done;
    assign owner_req = |(req_i & grant_o);
    assign busy_o = state == BURST;
    // A write is also suppressed in the reset cycle so an aborted burst never leaks a beat.
    assign fifo_wr_en_o = busy_o & owner_req & ~fifo_full_i & ~rst_i;
    assign ack_o = fifo_wr_en_o ? grant_o : '0;
    assign done = ~owner_req | (fifo_wr_en_o & (beat_cnt == CW'(MAX_BURST - 1)));
    // grant_o is zero outside BURST, so the mux yields zero data in IDLE.
    always_comb begin
        fifo_wr_data_o = '0;
        for (int n = 0; n < NUM_REQ; n++)
            if (grant_o[n]) fifo_wr_data_o = data_i[n*DATA_WIDTH +: DATA_WIDTH];
    end
    // Search starts just after the previous owner and wraps around.
    always_comb begin
        nxt_id = '0;
        cand   = '0;
        found  = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_WIDTH'((int'(last_owner) + i) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found  = 1'b1;
                nxt_id = cand;
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            grant_o    <= '0;
            grant_id_o <= '0;
            beat_cnt   <= '0;
            last_owner <= ID_WIDTH'(NUM_REQ - 1);
        end else if (state == IDLE) begin
            if (found) begin
                state      <= BURST;
                grant_o    <= NUM_REQ'(1) << nxt_id;
                grant_id_o <= nxt_id;
                beat_cnt   <= '0;
            end
        end else if (done) begin
            state      <= IDLE;
            grant_o    <= '0;
            grant_id_o <= '0;
            beat_cnt   <= '0;
            last_owner <= grant_id_o;
        end else if (fifo_wr_en_o) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  ack;
    logic        full;
    logic        we;
    logic [7:0]  wdata;
    logic [3:0]  grant;
    logic [1:0]  grant_id;
    logic        busy;
    int          total = 0;
    int          bad = 0;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .data_i(data), .ack_o(ack),
        .fifo_full_i(full), .fifo_wr_en_o(we), .fifo_wr_data_o(wdata),
        .grant_o(grant), .grant_id_o(grant_id), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; full = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'hF; full = 1'b0; data = 32'h0;
        tick();
        for (int i = 0; i < 3; i++) begin
            #3;
            total++; if (ack !== 4'h0) begin bad++; $display("FAIL rst_ack got=%h exp=0", ack); end
            total++; if (we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", we); end
            total++; if (grant !== 4'h0) begin bad++; $display("FAIL rst_grant got=%h exp=0", grant); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
            tick();
        end
        rst = 1'b0;
        #3;
        total++; if (we !== 1'b0) begin bad++; $display("FAIL rst_bubble got=%b exp=0", we); end
        tick();
        #3;
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL rst_first_grant got=%h exp=1", grant); end
        total++; if (ack !== 4'b0001) begin bad++; $display("FAIL rst_first_ack got=%h exp=1", ack); end
        req = '0;
        tick();
    endtask

    task automatic test_single_burst();
        logic exp_we   [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
        logic exp_busy [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
        logic [7:0] k = 8'hA0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            req = (c < 8) ? 4'b0100 : 4'b0000;
            data = '0;
            data[23:16] = k;
            #3;
            total++; if (we !== exp_we[c]) begin bad++; $display("FAIL sb_we cyc=%0d got=%b exp=%b", c, we, exp_we[c]); end
            total++; if (busy !== exp_busy[c]) begin bad++; $display("FAIL sb_busy cyc=%0d got=%b exp=%b", c, busy, exp_busy[c]); end
            if (exp_we[c]) begin
                total++; if (wdata !== k) begin bad++; $display("FAIL sb_data cyc=%0d got=%h exp=%h", c, wdata, k); end
                total++; if (ack !== 4'b0100) begin bad++; $display("FAIL sb_ack cyc=%0d got=%h exp=4", c, ack); end
                k++;
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] e;
        logic [1:0] id;
        do_reset();
        req = 4'hF;
        data = 32'hB3B2B1B0;
        for (int g = 0; g < 5; g++) begin
            id = 2'(g % 4);
            e = 4'b0001 << id;
            #3;
            total++; if (we !== 1'b0) begin bad++; $display("FAIL rr_bubble g=%0d got=%b exp=0", g, we); end
            tick();
            for (int b = 0; b < 4; b++) begin
                #3;
                total++; if (ack !== e) begin bad++; $display("FAIL rr_ack g=%0d b=%0d got=%h exp=%h", g, b, ack, e); end
                total++; if (grant_id !== id) begin bad++; $display("FAIL rr_id g=%0d b=%0d got=%0d exp=%0d", g, b, grant_id, id); end
                total++; if (wdata !== 8'hB0 + 8'(id)) begin bad++; $display("FAIL rr_data g=%0d got=%h exp=%h", g, wdata, 8'hB0 + 8'(id)); end
                tick();
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_full_stall();
        do_reset();
        req = 4'b0010;
        data = 32'h0000C100;
        #3;
        total++; if (we !== 1'b0) begin bad++; $display("FAIL fs_bubble got=%b exp=0", we); end
        tick();
        for (int i = 0; i < 2; i++) begin
            #3;
            total++; if (we !== 1'b1) begin bad++; $display("FAIL fs_pre_we i=%0d got=%b exp=1", i, we); end
            tick();
        end
        full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #3;
            total++; if (we !== 1'b0) begin bad++; $display("FAIL fs_stall_we i=%0d got=%b exp=0", i, we); end
            total++; if (ack !== 4'h0) begin bad++; $display("FAIL fs_stall_ack i=%0d got=%h exp=0", i, ack); end
            total++; if (grant !== 4'b0010) begin bad++; $display("FAIL fs_stall_grant i=%0d got=%h exp=2", i, grant); end
            tick();
        end
        full = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #3;
            total++; if (ack !== 4'b0010) begin bad++; $display("FAIL fs_post_ack i=%0d got=%h exp=2", i, ack); end
            tick();
        end
        #3;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fs_idle_busy got=%b exp=0", busy); end
        total++; if (we !== 1'b0) begin bad++; $display("FAIL fs_idle_we got=%b exp=0", we); end
        total++; if (grant !== 4'h0) begin bad++; $display("FAIL fs_idle_grant got=%h exp=0", grant); end
        req = '0;
        tick();
    endtask

    task automatic test_early_release();
        do_reset();
        req = 4'b1000;
        data = 32'hD3000000;
        #3;
        total++; if (we !== 1'b0) begin bad++; $display("FAIL er_bubble got=%b exp=0", we); end
        tick();
        req = 4'b1001;
        #3;
        total++; if (ack !== 4'b1000) begin bad++; $display("FAIL er_beat_ack got=%h exp=8", ack); end
        total++; if (wdata !== 8'hD3) begin bad++; $display("FAIL er_beat_data got=%h exp=d3", wdata); end
        tick();
        req = 4'b0001;
        #3;
        total++; if (ack !== 4'h0) begin bad++; $display("FAIL er_drop_ack got=%h exp=0", ack); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL er_drop_busy got=%b exp=1", busy); end
        tick();
        #3;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL er_idle_busy got=%b exp=0", busy); end
        tick();
        #3;
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL er_next_grant got=%h exp=1", grant); end
        total++; if (ack !== 4'b0001) begin bad++; $display("FAIL er_next_ack got=%h exp=1", ack); end
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req = 4'b0100;
        data = 32'h00E20000;
        tick();
        for (int i = 0; i < 2; i++) begin
            #3;
            total++; if (we !== 1'b1) begin bad++; $display("FAIL rm_we i=%0d got=%b exp=1", i, we); end
            tick();
        end
        rst = 1'b1;
        #3;
        total++; if (we !== 1'b0) begin bad++; $display("FAIL rm_rst_we got=%b exp=0", we); end
        total++; if (ack !== 4'h0) begin bad++; $display("FAIL rm_rst_ack got=%h exp=0", ack); end
        tick();
        rst = 1'b0;
        req = 4'b0110;
        #3;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_idle_busy got=%b exp=0", busy); end
        total++; if (grant !== 4'h0) begin bad++; $display("FAIL rm_idle_grant got=%h exp=0", grant); end
        tick();
        #3;
        total++; if (grant_id !== 2'd1) begin bad++; $display("FAIL rm_next_id got=%0d exp=1", grant_id); end
        total++; if (ack !== 4'b0010) begin bad++; $display("FAIL rm_next_ack got=%h exp=2", ack); end
        req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_full_stall();
        test_early_release();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
